// File: rtl/mem_line_arbiter_pkg.sv
// Shared definitions for the two-master line-memory arbiter.
//   state_t   : arbiter FSM states
//   GNT_*     : one-hot grant encodings (bit 0 = m0, bit 1 = m1)
package mem_line_arbiter_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/mem_line_arbiter_rr_arbiter2.sv
// Combinational two-way pick between m0 and m1.
//   req_i        : request vector, bit 0 = m0, bit 1 = m1
//   last_grant_i : one-hot owner of the previous transaction
//   pick_o       : one-hot winner, GNT_NONE when nobody requests
// On a tie, FIXED_PRIO != 0 always favours m1; otherwise the master
// that did not win last time is picked.
module mem_line_arbiter_rr_arbiter2
    import mem_line_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic [1:0] req_i,
    input  logic [1:0] last_grant_i,
    output logic [1:0] pick_o
);

    always_comb begin
        pick_o = GNT_NONE;
        case (req_i)
            2'b01: pick_o = GNT_M0;
            2'b10: pick_o = GNT_M1;
            2'b11: begin
                if (FIXED_PRIO != 0 || last_grant_i == GNT_M0) begin
                    pick_o = GNT_M1;
                end else begin
                    pick_o = GNT_M0;
                end
            end
            default: pick_o = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one 256-bit line memory port between the instruction-side MMU
// (m0) and the data-side MMU (m1).
//   clk, rst               : clock, synchronous active-high reset
//   mX_addr/data/rd/we_i   : master requests, held until mX_ack_o
//   mX_ack_o               : one-cycle completion to the granted master
//   m_data_o               : slave read data, broadcast to both masters
//   s_addr/data/rd/we_o    : registered slave request
//   s_data_i, s_ack_i      : slave read data and completion
//   grant_o                : one-hot owner of the current transaction
//   busy_o                 : a transaction is outstanding
//
// state  | meaning
// S_IDLE | strobes low; pick a requester and issue at the next edge
// S_BUSY | slave request held stable until s_ack_i
module mem_line_arbiter
    import mem_line_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_W     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [LINE_W-1:0] m0_data_i,
    input  logic              m0_rd_i,
    input  logic              m0_we_i,
    output logic              m0_ack_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [LINE_W-1:0] m1_data_i,
    input  logic              m1_rd_i,
    input  logic              m1_we_i,
    output logic              m1_ack_o,
    output logic [LINE_W-1:0] m_data_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [LINE_W-1:0] s_data_o,
    output logic              s_rd_o,
    output logic              s_we_o,
    input  logic [LINE_W-1:0] s_data_i,
    input  logic              s_ack_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [LINE_W-1:0] s_data_q, s_data_d;
    logic              s_rd_q, s_rd_d;
    logic              s_we_q, s_we_d;
    logic [1:0]        req;
    logic [1:0]        pick;

    assign req = {m1_rd_i | m1_we_i, m0_rd_i | m0_we_i};

    mem_line_arbiter_rr_arbiter2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_pick (
        .req_i       (req),
        .last_grant_i(last_grant_q),
        .pick_o      (pick)
    );

    // last_grant resets to m1 so m0 wins the first round-robin tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= GNT_NONE;
            last_grant_q <= GNT_M1;
            s_addr_q     <= '0;
            s_data_q     <= '0;
            s_rd_q       <= 1'b0;
            s_we_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            s_addr_q     <= s_addr_d;
            s_data_q     <= s_data_d;
            s_rd_q       <= s_rd_d;
            s_we_q       <= s_we_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_addr_d     = s_addr_q;
        s_data_d     = s_data_q;
        s_rd_d       = s_rd_q;
        s_we_d       = s_we_q;
        if (state_q == S_IDLE) begin
            if (pick != GNT_NONE) begin
                state_d      = S_BUSY;
                grant_d      = pick;
                last_grant_d = pick;
                if (pick == GNT_M1) begin
                    s_addr_d = m1_addr_i;
                    s_data_d = m1_data_i;
                    s_rd_d   = m1_rd_i;
                    s_we_d   = m1_we_i;
                end else begin
                    s_addr_d = m0_addr_i;
                    s_data_d = m0_data_i;
                    s_rd_d   = m0_rd_i;
                    s_we_d   = m0_we_i;
                end
            end
        end else begin
            // Master inputs are not looked at here: the issued request
            // stays frozen until the slave completes it.
            if (s_ack_i) begin
                state_d = S_IDLE;
                grant_d = GNT_NONE;
                s_rd_d  = 1'b0;
                s_we_d  = 1'b0;
            end
        end
    end

    // Acks are gated by the BUSY state so a stray slave ack while idle
    // never reaches a master.
    assign m0_ack_o = (state_q == S_BUSY) & s_ack_i & grant_q[0];
    assign m1_ack_o = (state_q == S_BUSY) & s_ack_i & grant_q[1];
    assign m_data_o = s_data_i;
    assign s_addr_o = s_addr_q;
    assign s_data_o = s_data_q;
    assign s_rd_o   = s_rd_q;
    assign s_we_o   = s_we_q;
    assign grant_o  = grant_q;
    assign busy_o   = (state_q == S_BUSY);

endmodule

// File: tb/tb_mem_line_arbiter.sv
module tb_mem_line_arbiter;

    localparam logic [1:0] G0 = 2'b00;
    localparam logic [1:0] GA = 2'b01;
    localparam logic [1:0] GB = 2'b10;
    localparam int         LAT = 3;

    logic         clk;
    logic         rst_rr, rst_fp;
    logic [31:0]  m0_addr, m1_addr;
    logic [255:0] m0_data, m1_data;
    logic         m0_rd, m0_we, m1_rd, m1_we;
    logic [255:0] s_rdata;
    logic         ack_rr, ack_fp, force_ack, s_ack_rr;
    bit           auto_en;

    logic         rr_m0_ack, rr_m1_ack, rr_s_rd, rr_s_we, rr_busy;
    logic [255:0] rr_m_data, rr_s_data;
    logic [31:0]  rr_s_addr;
    logic [1:0]   rr_grant;
    logic         fp_m0_ack, fp_m1_ack, fp_s_rd, fp_s_we, fp_busy;
    logic [255:0] fp_m_data, fp_s_data;
    logic [31:0]  fp_s_addr;
    logic [1:0]   fp_grant;

    int checks = 0;
    int errors = 0;
    int cnt_rr = 0;
    int cnt_fp = 0;

    logic [255:0] DATA_RD, DATA_M0, DATA_M1;

    assign s_ack_rr = ack_rr | force_ack;

    mem_line_arbiter #(.FIXED_PRIO(0), .ADDR_W(32), .LINE_W(256)) u_rr (
        .clk(clk), .rst(rst_rr),
        .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_rd_i(m0_rd), .m0_we_i(m0_we), .m0_ack_o(rr_m0_ack),
        .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_rd_i(m1_rd), .m1_we_i(m1_we), .m1_ack_o(rr_m1_ack),
        .m_data_o(rr_m_data), .s_addr_o(rr_s_addr), .s_data_o(rr_s_data), .s_rd_o(rr_s_rd), .s_we_o(rr_s_we),
        .s_data_i(s_rdata), .s_ack_i(s_ack_rr), .grant_o(rr_grant), .busy_o(rr_busy)
    );

    mem_line_arbiter #(.FIXED_PRIO(1), .ADDR_W(32), .LINE_W(256)) u_fp (
        .clk(clk), .rst(rst_fp),
        .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_rd_i(m0_rd), .m0_we_i(m0_we), .m0_ack_o(fp_m0_ack),
        .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_rd_i(m1_rd), .m1_we_i(m1_we), .m1_ack_o(fp_m1_ack),
        .m_data_o(fp_m_data), .s_addr_o(fp_s_addr), .s_data_o(fp_s_data), .s_rd_o(fp_s_rd), .s_we_o(fp_s_we),
        .s_data_i(s_rdata), .s_ack_i(ack_fp), .grant_o(fp_grant), .busy_o(fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: ack in the LAT-th cycle a strobe has been high.
    always @(posedge clk) begin
        #1;
        if (!auto_en || rst_rr) begin
            ack_rr = 1'b0; cnt_rr = 0;
        end else if (ack_rr) begin
            ack_rr = 1'b0; cnt_rr = 0;
        end else if (rr_s_rd || rr_s_we) begin
            cnt_rr++;
            if (cnt_rr == LAT) ack_rr = 1'b1;
        end
        if (!auto_en || rst_fp) begin
            ack_fp = 1'b0; cnt_fp = 0;
        end else if (ack_fp) begin
            ack_fp = 1'b0; cnt_fp = 0;
        end else if (fp_s_rd || fp_s_we) begin
            cnt_fp++;
            if (cnt_fp == LAT) ack_fp = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drop_all();
        m0_rd = 1'b0; m0_we = 1'b0; m1_rd = 1'b0; m1_we = 1'b0;
    endtask

    // Wait for the slave ack on the round-robin instance, check ack routing
    // on both instances, release the requests, and check the return to idle.
    task automatic run_to_ack(input string nm, input logic [1:0] g_rr, input logic [1:0] g_fp,
                              input logic [31:0] exp_addr);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (ack_rr) begin
                seen = 1'b1;
                chk({nm, "_rr_m0ack"}, rr_m0_ack, g_rr[0]);
                chk({nm, "_rr_m1ack"}, rr_m1_ack, g_rr[1]);
                chk({nm, "_fp_m0ack"}, fp_m0_ack, g_fp[0]);
                chk({nm, "_fp_m1ack"}, fp_m1_ack, g_fp[1]);
                chk({nm, "_mdata"}, rr_m_data, DATA_RD);
                chk({nm, "_addr_held"}, rr_s_addr, exp_addr);
                drop_all();
                tick();
                chk({nm, "_idle_busy"}, rr_busy, 1'b0);
                chk({nm, "_idle_grant"}, rr_grant, G0);
                chk({nm, "_idle_strb"}, {rr_s_rd, rr_s_we}, 2'b00);
            end
        end
        if (!seen) chk({nm, "_timeout"}, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic        m0_rd, m0_we, m1_rd, m1_we;
        logic [1:0]  exp_rr, exp_fp;
        logic        exp_rd, exp_we;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vt[7];
    logic [1:0] gseq[8];
    logic [1:0] fseq[8];
    int ng, nf;
    logic [1:0] prev_rr, prev_fp;
    bit done, after_m0, seen_m0;
    int bad;

    initial begin
        DATA_RD = {32{8'hA5}};
        DATA_M0 = {32{8'h22}};
        DATA_M1 = {32{8'h11}};
        s_rdata = DATA_RD;
        auto_en = 1'b1; force_ack = 1'b0; ack_rr = 1'b0; ack_fp = 1'b0;
        m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
        m0_data = DATA_M0; m1_data = DATA_M1;
        drop_all();

        //            m0rd  m0we  m1rd  m1we  rr  fp  rd    we    addr
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, GA, GA, 1'b1, 1'b0, 32'h0000_1000};
        vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, GB, GB, 1'b0, 1'b1, 32'h0000_2000};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, GA, GB, 1'b1, 1'b0, 32'h0000_1000};
        vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, GB, GB, 1'b1, 1'b0, 32'h0000_2000};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, GA, GB, 1'b1, 1'b0, 32'h0000_1000};
        vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, G0, G0, 1'b0, 1'b0, 32'h0000_0000};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, GA, GA, 1'b1, 1'b1, 32'h0000_1000};

        // Reset values
        rst_rr = 1'b1; rst_fp = 1'b1;
        tick(); tick();
        chk("rst_addr", rr_s_addr, 32'h0);
        chk("rst_data", rr_s_data, 256'h0);
        chk("rst_strb", {rr_s_rd, rr_s_we}, 2'b00);
        chk("rst_grant", rr_grant, G0);
        chk("rst_busy", rr_busy, 1'b0);
        chk("rst_fp_grant", fp_grant, G0);
        rst_rr = 1'b0;

        // Simultaneous m0 read / m1 write right after reset: m0 first.
        m0_rd = 1'b1; m1_we = 1'b1;
        tick();
        chk("b_addr", rr_s_addr, 32'h0000_1000);
        chk("b_rd", rr_s_rd, 1'b1);
        chk("b_grant", rr_grant, GA);
        ng = 1; gseq[0] = rr_grant; prev_rr = rr_grant;
        bad = 0; done = 1'b0; after_m0 = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (rr_m0_ack) begin
                chk("b_m0_mdata", rr_m_data, DATA_RD);
                chk("b_m1ack_quiet", rr_m1_ack, 1'b0);
                m0_rd = 1'b0;
                after_m0 = 1'b1;
            end
            if (rr_m1_ack) begin
                chk("b_m0ack_quiet", rr_m0_ack, 1'b0);
                m1_we = 1'b0;
            end
            tick();
            if (after_m0) begin
                chk("b_gap_strb", {rr_s_rd, rr_s_we}, 2'b00);
                after_m0 = 1'b0;
            end
            if (rr_grant != prev_rr && ng < 8) begin
                gseq[ng] = rr_grant; ng++;
            end
            prev_rr = rr_grant;
            if (rr_s_we != (rr_grant == GB)) bad++;
            if (rr_grant == GB && rr_s_data != DATA_M1) bad++;
            if (!m0_rd && !m1_we && !rr_busy) done = 1'b1;
        end
        chk("b_done", done, 1'b1);
        chk("b_we_only_m1", bad, 0);
        chk("b_nseq", ng, 4);
        chk("b_seq0", gseq[0], GA);
        chk("b_seq1", gseq[1], G0);
        chk("b_seq2", gseq[2], GB);
        chk("b_seq3", gseq[3], G0);

        // Table of single transactions, both instances running.
        rst_fp = 1'b0;
        for (int i = 0; i < 7; i++) begin
            m0_rd = vt[i].m0_rd; m0_we = vt[i].m0_we;
            m1_rd = vt[i].m1_rd; m1_we = vt[i].m1_we;
            tick();
            chk($sformatf("v%0d_rr_grant", i), rr_grant, vt[i].exp_rr);
            chk($sformatf("v%0d_fp_grant", i), fp_grant, vt[i].exp_fp);
            chk($sformatf("v%0d_busy", i), rr_busy, vt[i].exp_rr != G0);
            chk($sformatf("v%0d_rd", i), rr_s_rd, vt[i].exp_rd);
            chk($sformatf("v%0d_we", i), rr_s_we, vt[i].exp_we);
            if (vt[i].exp_rr != G0) begin
                chk($sformatf("v%0d_addr", i), rr_s_addr, vt[i].exp_addr);
                run_to_ack($sformatf("v%0d", i), vt[i].exp_rr, vt[i].exp_fp, vt[i].exp_addr);
            end else begin
                drop_all();
                tick();
            end
        end

        // Continuous requests: alternation on round-robin, m1 always on fixed.
        m1_rd = 1'b1;
        prev_rr = rr_grant; prev_fp = fp_grant;
        ng = 0; nf = 0; seen_m0 = 1'b0;
        for (int c = 0; c < 80 && (ng < 4 || nf < 4); c++) begin
            tick();
            if (rr_grant != G0 && prev_rr == G0 && ng < 8) begin gseq[ng] = rr_grant; ng++; end
            if (fp_grant != G0 && prev_fp == G0 && nf < 8) begin fseq[nf] = fp_grant; nf++; end
            prev_rr = rr_grant; prev_fp = fp_grant;
            if (fp_m0_ack) seen_m0 = 1'b1;
            if (ng >= 1) m0_rd = 1'b1;
        end
        chk("c_nrr", ng, 4);
        chk("c_nfp", nf, 4);
        chk("c_rr0", gseq[0], GB);
        chk("c_rr1", gseq[1], GA);
        chk("c_rr2", gseq[2], GB);
        chk("c_rr3", gseq[3], GA);
        for (int k = 0; k < 4; k++) chk($sformatf("c_fp%0d", k), fseq[k], GB);
        chk("c_fp_m0_starved", seen_m0, 1'b0);
        m1_rd = 1'b0;
        for (int c = 0; c < 40 && !seen_m0; c++) begin
            tick();
            if (fp_m0_ack) seen_m0 = 1'b1;
        end
        chk("c_fp_m0_after_drop", seen_m0, 1'b1);
        m0_rd = 1'b0;
        for (int c = 0; c < 20 && (rr_busy || fp_busy); c++) tick();
        chk("c_idle", {rr_busy, fp_busy}, 2'b00);

        // Reset during BUSY, stray ack while idle, then a fresh request.
        rst_fp = 1'b1;
        auto_en = 1'b0;
        m0_addr = 32'h0000_4000; m0_rd = 1'b1;
        tick();
        chk("d_busy", rr_busy, 1'b1);
        tick();
        m0_rd = 1'b0; rst_rr = 1'b1;
        tick();
        rst_rr = 1'b0;
        chk("d_strb", {rr_s_rd, rr_s_we}, 2'b00);
        chk("d_grant", rr_grant, G0);
        chk("d_busy0", rr_busy, 1'b0);
        chk("d_acks", {rr_m0_ack, rr_m1_ack}, 2'b00);
        force_ack = 1'b1;
        #1;
        chk("d_late_ack", {rr_m0_ack, rr_m1_ack}, 2'b00);
        tick();
        force_ack = 1'b0;
        chk("d_still_idle", rr_busy, 1'b0);
        auto_en = 1'b1;
        m0_addr = 32'h0000_5000; m0_rd = 1'b1;
        tick();
        chk("d_fresh_grant", rr_grant, GA);
        chk("d_fresh_addr", rr_s_addr, 32'h0000_5000);
        run_to_ack("d_fresh", GA, G0, 32'h0000_5000);

        // Address changes mid-transaction are not picked up.
        m0_addr = 32'h0000_3000; m0_rd = 1'b1;
        tick();
        chk("e_addr", rr_s_addr, 32'h0000_3000);
        m0_addr = 32'h0000_3FFF; m0_data = DATA_M1;
        tick();
        chk("e_addr_hold", rr_s_addr, 32'h0000_3000);
        chk("e_data_hold", rr_s_data, DATA_M0);
        run_to_ack("e", GA, G0, 32'h0000_3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
Two-master arbiter that shares the single 256-bit line memory port between the instruction-side MMU (m0) and the data-side MMU (m1). It uses the line-bus handshake: the master holds rd/we with addr/data until a one-cycle ack, and the ack cycle carries the read data. Requests are registered onto the slave port, acks are routed back to the granted master only, and the bus is guaranteed one idle cycle between transactions.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between m0 and m1; 1 = m1 (data side) always wins a tie.
ADDR_W, 32, address width.
LINE_W, 256, line data width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m0_addr_i  in  ADDR_W  master 0 address
m0_data_i  in  LINE_W  master 0 write data
m0_rd_i  in  1  master 0 read request
m0_we_i  in  1  master 0 write request
m0_ack_o  out  1  master 0 completion, one cycle
m1_addr_i / m1_data_i / m1_rd_i / m1_we_i / m1_ack_o  same as m0, for master 1
m_data_o  out  LINE_W  read data broadcast to both masters, equal to s_data_i
s_addr_o  out  ADDR_W  slave address, registered
s_data_o  out  LINE_W  slave write data, registered
s_rd_o  out  1  slave read strobe, registered
s_we_o  out  1  slave write strobe, registered
s_data_i  in  LINE_W  slave read data, valid with s_ack_i
s_ack_i  in  1  slave completion
grant_o  out  2  one-hot owner of the current transaction; 0 when idle
busy_o  out  1  high in S_BUSY

Behaviour:
- Reset values:
  - s_addr_o=0, s_data_o=0, s_rd_o=0, s_we_o=0, grant_o=0, busy_o=0.
  - state=S_IDLE, last_grant=m1, so m0 wins the first round-robin tie.
  - Reset in S_BUSY aborts the transaction without an ack to any master.
- A master "requests" when rd_i | we_i. rd and we are forwarded as-is; the slave resolves rd=we=1.
- State S_IDLE:
  - No request: stay.
  - One requester: grant it.
  - Both request: FIXED_PRIO=1 grants m1. FIXED_PRIO=0 grants the master not equal to last_grant.
  - On grant, at the next edge: latch the winner's addr/data/rd/we into the s_* outputs, set grant_o, last_grant and busy_o, go to S_BUSY.
  - Latency: request seen in cycle N gives s_rd_o/s_we_o high in cycle N+1.
- State S_BUSY:
  - s_* outputs hold stable. Master inputs are ignored, including changed addr.
  - On s_ack_i=1, combinationally in the same cycle: mX_ack_o=1 for the granted master only; the other master's ack stays 0.
  - m_data_o is wired to s_data_i in all states; masters qualify it with their ack.
  - At that edge: s_rd_o=0, s_we_o=0, grant_o=0, busy_o=0, go to S_IDLE.
  - The S_IDLE cycle guarantees the slave sees strobes low for at least 1 cycle between transactions. Back-to-back throughput is one transaction per (slave latency + 1 idle + 1 issue) cycles.
- s_ack_i while S_IDLE: ignored, no master ack.
- Granted master drops its request before ack (protocol violation): the slave transaction still completes; the ack is still pulsed to that master; no retry.
- Round-robin fairness: a master continuously requesting cannot be granted twice in a row while the other is requesting.
- mX_ack_o is never asserted when grant_o[X]=0.

Decomposition:
- Shared package/header: state encodings S_IDLE=0, S_BUSY=1; grant one-hot constants GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10.
- Natural sub-module: rr_arbiter2, a combinational 2-way pick taking req[1:0], last_grant and FIXED_PRIO, returning a one-hot pick.
- Everything else stays in mem_line_arbiter.

Test Plan:
- m0 read addr=0x0000_1000 alone; slave acks 3 cycles after s_rd_o rises with data=0xA5.. → s_addr_o=0x0000_1000 one cycle after the request; m0_ack_o=1 exactly in the s_ack_i cycle with m_data_o=0xA5..; m1_ack_o=0; s_rd_o=0 for at least 1 cycle afterward.
- m0 read and m1 write (addr 0x2000, data 0x11..) in the same cycle after reset, FIXED_PRIO=0 → m0 served first, then m1; grant_o sequence 01,00,10,00; s_we_o=1 only during m1's transaction with s_data_o=0x11...
- m1 requests continuously and m0 requests from cycle 5 onward → grants alternate m1,m0,m1,m0; no master gets two consecutive grants while the other is pending.
- FIXED_PRIO=1, both requesting continuously → m1 granted every transaction; m0_ack_o stays 0 until m1 drops its request.
- rst asserted while in S_BUSY before the ack → the next cycle has all s_* strobes 0, grant_o=0, and no ack to either master; a late s_ack_i is ignored; a fresh m0 request is then served normally.
- s_ack_i pulsed while idle, and m0 changing addr mid-transaction → no master ack for the idle pulse; s_addr_o keeps the originally latched address until the ack.
